// File: rtl/write_ptr_ctrl.sv
// write_ptr_ctrl: write-side pointer and flag controller for the async FIFO (wclk domain).
// Holds the binary/Gray write pointers and registered full, almost-full, occupancy and
// sticky overflow flags, plus a programmable almost-full threshold.
// Optional feature: define WOVF_COUNT_EN to add wovf_cnt, a saturating rejected-write count.
module write_ptr_ctrl #(
    parameter int ADDRESS_BITS    = 4,
    parameter int AF_RESET_THRESH = (2**ADDRESS_BITS) - 2
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic                    winc,
    input  logic [ADDRESS_BITS:0]   wq2_read_ptr,
    input  logic [ADDRESS_BITS:0]   wafull_thresh,
    input  logic                    wafull_ld,
    input  logic                    wovf_clr,
    output logic [ADDRESS_BITS-1:0] waddr,
    output logic [ADDRESS_BITS:0]   wptr,
    output logic                    wen,
    output logic                    wfull,
    output logic                    walmost_full,
    output logic [ADDRESS_BITS:0]   wcount,
`ifdef WOVF_COUNT_EN
    output logic [7:0]              wovf_cnt,
`endif
    output logic                    wovf
);
    localparam int A = ADDRESS_BITS;
    localparam int W = ADDRESS_BITS + 1;
    localparam logic [A:0] DEPTH   = {1'b1, {A{1'b0}}};
    localparam logic [A:0] AF_INIT = W'(AF_RESET_THRESH);

    logic [A:0] wbin;
    logic [A:0] wbinnext;
    logic [A:0] wgraynext;
    logic [A:0] rbin;
    logic [A:0] occ_next;
    logic [A:0] full_ptr;
    logic [A:0] thresh;
    logic [A:0] thresh_in;
    logic       reject;

    assign wen       = winc & ~wfull;
    assign reject    = winc & wfull;
    assign wbinnext  = wbin + W'(wen);
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;
    assign occ_next  = wbinnext - rbin;
    assign waddr     = wbin[A-1:0];
    // Read pointer that the write pointer equals when exactly one lap ahead
    assign full_ptr  = {~wq2_read_ptr[A:A-1], wq2_read_ptr[A-2:0]};
    // Thresholds above the depth could never be reached; clamp to the depth
    assign thresh_in = (wafull_thresh > DEPTH) ? DEPTH : wafull_thresh;

    // Gray-to-binary of the synchronised read pointer: each bit is the XOR of itself and all higher bits
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= A; i++) begin
            rbin[i] = ^(wq2_read_ptr >> i);
        end
    end

    // Pointer, full, occupancy and almost-full registers
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            wcount       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= (wgraynext == full_ptr);
            wcount       <= occ_next;
            walmost_full <= (occ_next >= thresh);
        end
    end

    // Almost-full threshold register; a load takes effect on the following edge's compare
    always_ff @(posedge wclk) begin
        if (wrst)           thresh <= AF_INIT;
        else if (wafull_ld) thresh <= thresh_in;
    end

    // Sticky overflow flag; a new rejection wins over a simultaneous clear
    always_ff @(posedge wclk) begin
        if (wrst)          wovf <= 1'b0;
        else if (reject)   wovf <= 1'b1;
        else if (wovf_clr) wovf <= 1'b0;
    end

`ifdef WOVF_COUNT_EN
    // Saturating rejected-write counter; a rejection during clear restarts the count at 1
    always_ff @(posedge wclk) begin
        if (wrst)                        wovf_cnt <= 8'd0;
        else if (wovf_clr)               wovf_cnt <= reject ? 8'd1 : 8'd0;
        else if (reject && wovf_cnt != 8'hFF) wovf_cnt <= wovf_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_write_ptr_ctrl.sv
// tb_write_ptr_ctrl: directed test of write_ptr_ctrl at ADDRESS_BITS=4 (depth 16, reset threshold 14).
module tb_write_ptr_ctrl;
    logic       wclk;
    logic       wrst;
    logic       winc;
    logic [4:0] wq2_read_ptr;
    logic [4:0] wafull_thresh;
    logic       wafull_ld;
    logic       wovf_clr;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wen;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wcount;
    logic       wovf;
`ifdef WOVF_COUNT_EN
    logic [7:0] wovf_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    write_ptr_ctrl #(.ADDRESS_BITS(4), .AF_RESET_THRESH(14)) dut (
        .wclk          (wclk),
        .wrst          (wrst),
        .winc          (winc),
        .wq2_read_ptr  (wq2_read_ptr),
        .wafull_thresh (wafull_thresh),
        .wafull_ld     (wafull_ld),
        .wovf_clr      (wovf_clr),
        .waddr         (waddr),
        .wptr          (wptr),
        .wen           (wen),
        .wfull         (wfull),
        .walmost_full  (walmost_full),
        .wcount        (wcount),
`ifdef WOVF_COUNT_EN
        .wovf_cnt      (wovf_cnt),
`endif
        .wovf          (wovf)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] gray(input int k);
        logic [4:0] b;
        b = 5'(k);
        return b ^ (b >> 1);
    endfunction

    initial begin
        // 1. Reset held two cycles with winc high
        wrst = 1'b1; winc = 1'b1; wq2_read_ptr = '0; wafull_thresh = '0;
        wafull_ld = 1'b0; wovf_clr = 1'b0;
        tick(); tick();
        wrst = 1'b0; winc = 1'b0;
        chk("rst_waddr", waddr, 0);
        chk("rst_wptr", wptr, 0);
        chk("rst_wcount", wcount, 0);
        chk("rst_wfull", wfull, 0);
        chk("rst_wafull", walmost_full, 0);
        chk("rst_wovf", wovf, 0);

        // 2. Fill with 16 writes
        winc = 1'b1; #1;
        chk("fill_wen", wen, 1);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("fill_wcount_%0d", i), wcount, i);
            chk($sformatf("fill_wafull_%0d", i), walmost_full, (i >= 14) ? 1 : 0);
            chk($sformatf("fill_wfull_%0d", i), wfull, (i == 16) ? 1 : 0);
        end
        chk("fill_wptr", wptr, 5'b11000);
        chk("fill_waddr", waddr, 0);

        // 3. Overflow: three rejected writes, then clear
        #1;
        chk("ovf_wen", wen, 0);
        tick(); tick(); tick();
        chk("ovf_wptr", wptr, 5'b11000);
        chk("ovf_wcount", wcount, 16);
        chk("ovf_wfull", wfull, 1);
        chk("ovf_wovf", wovf, 1);
`ifdef WOVF_COUNT_EN
        chk("ovf_cnt3", wovf_cnt, 3);
`endif
        winc = 1'b0; wovf_clr = 1'b1;
        tick();
        wovf_clr = 1'b0;
        chk("ovf_clr", wovf, 0);
`ifdef WOVF_COUNT_EN
        chk("ovf_cnt_clr", wovf_cnt, 0);
`endif

        // 4. Drain via read-pointer steps, then write across the wrap
        for (int k = 1; k <= 16; k++) begin
            wq2_read_ptr = gray(k);
            tick();
            chk($sformatf("drain_wcount_%0d", k), wcount, 16 - k);
            chk($sformatf("drain_wfull_%0d", k), wfull, 0);
        end
        for (int j = 1; j <= 20; j++) begin
            winc = 1'b1;
            tick();
            chk($sformatf("wrap_wcount_%0d", j), wcount, 1);
            chk($sformatf("wrap_wfull_%0d", j), wfull, 0);
            if (j == 15) chk("wrap_wptr_31", wptr, 5'b10000);
            if (j == 16) chk("wrap_wptr_0", wptr, 5'b00000);
            wq2_read_ptr = gray(16 + j);
        end
        winc = 1'b0;
        tick();
        chk("wrap_wptr_end", wptr, 5'b00110);
        chk("wrap_waddr_end", waddr, 4);
        chk("wrap_wcount_end", wcount, 0);

        // 5. Threshold load to 4, then 4 writes
        wafull_ld = 1'b1; wafull_thresh = 5'd4;
        tick();
        wafull_ld = 1'b0; winc = 1'b1;
        tick(); tick(); tick();
        chk("thr4_wafull_3", walmost_full, 0);
        tick();
        chk("thr4_wafull_4", walmost_full, 1);
        chk("thr4_wcount_4", wcount, 4);
        // Oversized threshold clamps to 16
        winc = 1'b0; wafull_ld = 1'b1; wafull_thresh = 5'd31;
        tick();
        wafull_ld = 1'b0; winc = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        chk("clamp_wcount_15", wcount, 15);
        chk("clamp_wafull_15", walmost_full, 0);
        tick();
        chk("clamp_wfull_16", wfull, 1);
        chk("clamp_wafull_16", walmost_full, 1);

        // 6. Rejection and clear together: set wins
        tick();
        chk("sim_wovf_set", wovf, 1);
        wovf_clr = 1'b1;
        tick();
        chk("sim_wovf_hold", wovf, 1);
`ifdef WOVF_COUNT_EN
        chk("sim_cnt_1", wovf_cnt, 1);
`endif
        wovf_clr = 1'b0; winc = 1'b0;

        // Reset out of a full state, then partial fill and reset mid-burst
        wrst = 1'b1; wq2_read_ptr = '0;
        tick();
        wrst = 1'b0;
        winc = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_wcount_5", wcount, 5);
        wrst = 1'b1;
        tick();
        wrst = 1'b0; winc = 1'b0;
        chk("mid_waddr", waddr, 0);
        chk("mid_wptr", wptr, 0);
        chk("mid_wcount", wcount, 0);
        chk("mid_wfull", wfull, 0);
        chk("mid_wafull", walmost_full, 0);
        chk("mid_wovf", wovf, 0);
        // Threshold back to 14
        winc = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        chk("rthr_wafull_13", walmost_full, 0);
        tick();
        chk("rthr_wafull_14", walmost_full, 1);
        winc = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
